sfifo_cnt: RTL and testbench

Parametrised synchronous FIFO for single-clock buffering between AXI-side logic and the MIG user interface. It has true full/empty detection over the whole depth and a programmable almost-full slack so pipelined producers can stop in time. It also provides occupancy count, almost-empty, synchronous flush and optional sticky error flags. Read data is show-ahead: the head entry is always presented on `rdata`.

---
 rtl/sfifo_pkg.sv | 14 +
 rtl/sfifo_ram.sv | 28 ++
 rtl/sfifo_cnt.sv | 103 ++++++++++
 tb/tb_sfifo_cnt.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sfifo_pkg.sv
// Shared sizing helpers for the sfifo_cnt FIFO and its storage array.
package sfifo_pkg;

  // Number of entries for a given address width.
  function automatic int unsigned sfifodp(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned sfifo_ptr_w(input int unsigned aw);
    return aw + 32'd1;
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// 1R1W register array: synchronous write, asynchronous read, no control logic.
module sfifo_ram
  import sfifo_pkg::*;
#(
  parameter int unsigned SFIFODW = 32,
  parameter int unsigned SFIFOAW = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [SFIFOAW-1:0] waddr,
  input  logic [SFIFODW-1:0] wdata,
  input  logic [SFIFOAW-1:0] raddr,
  output logic [SFIFODW-1:0] rdata
);

  localparam int unsigned SFIFODP = sfifodp(SFIFOAW);

  logic [SFIFODW-1:0] mem [SFIFODP];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_cnt.sv
// Show-ahead synchronous FIFO with occupancy count, almost-full/empty flags and flush.
// Define SFIFO_ERRCHK_EN to enable the sticky ovf/udf error flags (otherwise tied to 0).
module sfifo_cnt
  import sfifo_pkg::*;
#(
  parameter int unsigned SFIFODW     = 32,
  parameter int unsigned SFIFOAW     = 2,
  parameter int unsigned AFULL_SLACK = 2,
  parameter int unsigned AEMPTY_LVL  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wen,
  input  logic [SFIFODW-1:0] wdata,
  output logic               wfull,
  output logic               wqfull,
  input  logic               rnext,
  output logic [SFIFODW-1:0] rdata,
  output logic               rqempty,
  output logic               raempty,
  output logic [SFIFOAW:0]   count,
  output logic               ovf,
  output logic               udf
);

  localparam int unsigned SFIFODP = sfifodp(SFIFOAW);
  localparam int unsigned PTR_W   = sfifo_ptr_w(SFIFOAW);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             wacc, racc;
  logic [31:0]      free_slots;

  assign count   = wptr_q - rptr_q;
  assign rqempty = (wptr_q == rptr_q);
  assign wfull   = (wptr_q[SFIFOAW-1:0] == rptr_q[SFIFOAW-1:0]) &&
                   (wptr_q[SFIFOAW] != rptr_q[SFIFOAW]);

  // Compare in 32 bits so an out-of-range slack cannot truncate.
  assign free_slots = SFIFODP - 32'(count);
  assign wqfull     = wfull || (free_slots <= AFULL_SLACK);
  assign raempty    = 32'(count) <= AEMPTY_LVL;

  assign wacc = wen & ~wfull;
  assign racc = rnext & ~rqempty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wacc) wptr_d = wptr_q + 1'b1;
      if (racc) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

`ifdef SFIFO_ERRCHK_EN
  logic ovf_q, udf_q;

  // Sticky until reset; flush deliberately leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wen && wfull)     ovf_q <= 1'b1;
      if (rnext && rqempty) udf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  sfifo_ram #(
    .SFIFODW(SFIFODW),
    .SFIFOAW(SFIFOAW)
  ) u_ram (
    .clk  (clk),
    .we   (wacc && !flush),
    .waddr(wptr_q[SFIFOAW-1:0]),
    .wdata(wdata),
    .raddr(rptr_q[SFIFOAW-1:0]),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_sfifo_cnt.sv
// Directed self-checking bench for sfifo_cnt (32-bit, depth 4, slack 2, aempty level 1).
module tb_sfifo_cnt;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wen;
  logic [31:0] wdata;
  logic        wfull;
  logic        wqfull;
  logic        rnext;
  logic [31:0] rdata;
  logic        rqempty;
  logic        raempty;
  logic [2:0]  count;
  logic        ovf;
  logic        udf;

  int unsigned n_checks;
  int unsigned n_errors;

`ifdef SFIFO_ERRCHK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  sfifo_cnt #(
    .SFIFODW    (32),
    .SFIFOAW    (2),
    .AFULL_SLACK(2),
    .AEMPTY_LVL (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .wen    (wen),
    .wdata  (wdata),
    .wfull  (wfull),
    .wqfull (wqfull),
    .rnext  (rnext),
    .rdata  (rdata),
    .rqempty(rqempty),
    .raempty(raempty),
    .count  (count),
    .ovf    (ovf),
    .udf    (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    flush = 1'b0;
    wen   = 1'b0;
    rnext = 1'b0;
    wdata = '0;

    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_rqempty", 32'(rqempty), 32'd1);
    check("rst_raempty", 32'(raempty), 32'd1);
    check("rst_wfull", 32'(wfull), 32'd0);
    check("rst_wqfull", 32'(wqfull), 32'd0);
    rst = 1'b0;
    tick();

    // 1. Fill
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1;
      wdata = 32'hA0 + 32'(i);
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_wqfull", 32'(wqfull), (i >= 1) ? 32'd1 : 32'd0);
      check("fill_wfull", 32'(wfull), (i == 3) ? 32'd1 : 32'd0);
      check("fill_raempty", 32'(raempty), (i == 0) ? 32'd1 : 32'd0);
      check("fill_head", rdata, 32'hA0);
    end
    wdata = 32'hA4;
    tick();
    wen = 1'b0;
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(ovf), 32'(ERR_ON));

    // 2. Drain
    for (int i = 0; i < 4; i++) begin
      check("drain_rdata", rdata, 32'hA0 + 32'(i));
      rnext = 1'b1;
      tick();
      check("drain_count", 32'(count), 32'(3 - i));
      check("drain_rqempty", 32'(rqempty), (i == 3) ? 32'd1 : 32'd0);
    end
    check("pre_udf_flag", 32'(udf), 32'd0);
    tick();
    rnext = 1'b0;
    check("udf_count", 32'(count), 32'd0);
    check("udf_flag", 32'(udf), 32'(ERR_ON));

    // 3. Wrap-around at count=2 with simultaneous read/write
    wen = 1'b1;
    wdata = 32'hF0;
    tick();
    wdata = 32'hF1;
    tick();
    check("wrap_pre_count", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      check("wrap_rdata", rdata, (i == 0) ? 32'hF0 : (i == 1) ? 32'hF1 : 32'(i - 2));
      wen = 1'b1;
      rnext = 1'b1;
      wdata = 32'(i);
      tick();
      check("wrap_count", 32'(count), 32'd2);
    end
    rnext = 1'b0;

    // 4. Full with simultaneous read and write
    wdata = 32'h10;
    tick();
    wdata = 32'h11;
    tick();
    wen = 1'b0;
    check("full_count", 32'(count), 32'd4);
    check("full_wfull", 32'(wfull), 32'd1);
    check("full_head", rdata, 32'h08);
    wen = 1'b1;
    rnext = 1'b1;
    wdata = 32'hBB;
    tick();
    wen = 1'b0;
    rnext = 1'b0;
    check("fullrw_count", 32'(count), 32'd3);
    check("fullrw_wfull", 32'(wfull), 32'd0);
    check("fullrw_head", rdata, 32'h09);

    // 5. Flush beats a concurrent write
    flush = 1'b1;
    wen = 1'b1;
    wdata = 32'hCC;
    tick();
    flush = 1'b0;
    wen = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_rqempty", 32'(rqempty), 32'd1);
    check("flush_wqfull", 32'(wqfull), 32'd0);
    check("flush_ovf", 32'(ovf), 32'(ERR_ON));
    check("flush_udf", 32'(udf), 32'(ERR_ON));
    wen = 1'b1;
    wdata = 32'h55;
    tick();
    wen = 1'b0;
    check("postflush_count", 32'(count), 32'd1);
    check("postflush_head", rdata, 32'h55);

    // 6. Asynchronous reset mid-cycle at count=2
    wen = 1'b1;
    wdata = 32'h66;
    tick();
    wen = 1'b0;
    check("prerst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_rqempty", 32'(rqempty), 32'd1);
    check("arst_ovf", 32'(ovf), 32'd0);
    check("arst_udf", 32'(udf), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    check("postrst_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
